// File: rtl/gmsk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gmsk_pkg
//  Brief    : Shared types and constants for the GMSK transmit sequencer:
//             FSM state encoding, default timing parameters and quadrant steps.
//  Revision : 1.0  initial release
// ============================================================================
package gmsk_pkg;

    // Burst framing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } gmsk_state_e;

    localparam int DEF_CLOCKS_PER_SAMPLE  = 8;
    localparam int DEF_SAMPLES_PER_SYMBOL = 128;
    localparam int DEF_TAIL_BITS          = 3;

    // Phase quadrant bookkeeping: a differential 1 rotates +90 deg, a 0 rotates -90 deg
    localparam logic [1:0] QUAD_ZERO     = 2'd0;
    localparam logic [1:0] QUAD_STEP_POS = 2'd1;
    localparam logic [1:0] QUAD_STEP_NEG = 2'd3;

    // Next phase quadrant for a differentially encoded bit
    function automatic logic [1:0] quad_next(input logic [1:0] quad, input logic d);
        return quad + (d ? QUAD_STEP_POS : QUAD_STEP_NEG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gmsk_strobe_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gmsk_strobe_gen
//  Brief    : Clock divider and per-symbol sample counter. Produces the sample
//             and symbol strobes plus the sample index within the symbol.
//             A synchronous hold input parks both counters at zero.
//  Revision : 1.0  initial release
// ============================================================================
module gmsk_strobe_gen
    import gmsk_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = DEF_CLOCKS_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
    parameter int IDX_W              = $clog2(SAMPLES_PER_SYMBOL)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             hold,
    output logic             sample_strobe,
    output logic             symbol_strobe,
    output logic [IDX_W-1:0] scnt
);

    localparam int               DIV_W     = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [IDX_W-1:0] SCNT_LAST = IDX_W'(SAMPLES_PER_SYMBOL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] scnt_q, scnt_d;

    // Strobe decode and next-count logic; enable low freezes the counters
    always_comb begin
        sample_strobe = enable && !hold && (div_q == DIV_LAST);
        symbol_strobe = sample_strobe && (scnt_q == SCNT_LAST);
        div_d         = div_q;
        scnt_d        = scnt_q;
        if (hold) begin
            div_d  = '0;
            scnt_d = '0;
        end else if (enable) begin
            div_d = sample_strobe ? '0 : div_q + DIV_W'(1);
            if (sample_strobe) begin
                scnt_d = (scnt_q == SCNT_LAST) ? '0 : scnt_q + IDX_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            scnt_q <= '0;
        end else begin
            div_q  <= div_d;
            scnt_q <= scnt_d;
        end
    end

    assign scnt = scnt_q;

endmodule
`default_nettype wire

// File: rtl/gmsk_tx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gmsk_tx_sequencer
//  Brief    : GMSK modulator sequencer. Frames a burst (head zeros, payload,
//             tail zeros), differentially encodes the bit stream, tracks a
//             3-symbol history and phase quadrant, and emits per-sample ROM
//             index, curve select and sign-fixup control.
//  Revision : 1.0  initial release
// ============================================================================
module gmsk_tx_sequencer
    import gmsk_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = DEF_CLOCKS_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
    parameter int IDX_W              = $clog2(SAMPLES_PER_SYMBOL),
    parameter int TAIL_BITS          = DEF_TAIL_BITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             burst_start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             bit_last,
    output logic             bit_ready,
    output logic             sample_strobe,
    output logic             symbol_strobe,
    output logic [IDX_W-1:0] rom_index,
    output logic [1:0]       curve_sel,
    output logic             negate,
    output logic             busy,
    output logic             underrun
);

    localparam int                TCNT_W    = (TAIL_BITS > 1) ? $clog2(TAIL_BITS) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TAIL_BITS - 1);

    gmsk_state_e       state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              b_prev_q, b_prev_d;
    logic [2:0]        hist_q, hist_d;
    logic [1:0]        quad_q, quad_d;
    logic [IDX_W-1:0]  rom_index_q, rom_index_d;
    logic [1:0]        curve_sel_q, curve_sel_d;
    logic              negate_q, negate_d;
    logic              busy_q, busy_d;

    logic              hold;
    logic              consume;
    logic              sym_bit;
    logic              d_bit;
    logic [IDX_W-1:0]  scnt;

    // Counters run only while a burst is in progress
    gmsk_strobe_gen #(
        .CLOCKS_PER_SAMPLE  (CLOCKS_PER_SAMPLE),
        .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL),
        .IDX_W              (IDX_W)
    ) u_strobe_gen (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .hold          (hold),
        .sample_strobe (sample_strobe),
        .symbol_strobe (symbol_strobe),
        .scnt          (scnt)
    );

    // Payload handshake: one bit offered per DATA symbol boundary; a missing bit becomes a 0
    always_comb begin
        hold      = (state_q == IDLE);
        bit_ready = (state_q == DATA) && symbol_strobe;
        consume   = bit_ready && bit_valid;
        underrun  = bit_ready && !bit_valid;
        sym_bit   = consume ? bit_in : 1'b0;
        d_bit     = sym_bit ^ b_prev_q;
    end

    // Framing FSM, differential encoder and per-sample output next-state
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        b_prev_d    = b_prev_q;
        hist_d      = hist_q;
        quad_d      = quad_q;
        rom_index_d = rom_index_q;
        curve_sel_d = curve_sel_q;
        negate_d    = negate_q;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (enable && burst_start) begin
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (symbol_strobe) begin
                    if (tcnt_q == TCNT_LAST) begin
                        state_d = DATA;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (consume && bit_last) begin
                    state_d = TAIL;
                    tcnt_d  = '0;
                end
            end
            TAIL: begin
                if (symbol_strobe) begin
                    if (tcnt_q == TCNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (symbol_strobe && (state_q != IDLE)) begin
            b_prev_d = sym_bit;
            hist_d   = {hist_q[1:0], d_bit};
            quad_d   = quad_next(quad_q, d_bit);
        end

        // Output values reflect the symbol in flight; the quadrant moves only after its last sample
        if (sample_strobe) begin
            rom_index_d = quad_q[0] ? ({IDX_W{1'b0}} - scnt) : scnt;
            curve_sel_d = {hist_q[2] ^ hist_q[1], hist_q[1] ^ hist_q[0]};
            negate_d    = quad_q[1];
        end

        // Burst end (or idling) leaves the encoder and outputs in their rest state
        if (state_d == IDLE) begin
            b_prev_d    = 1'b0;
            hist_d      = '0;
            quad_d      = QUAD_ZERO;
            rom_index_d = '0;
            curve_sel_d = '0;
            negate_d    = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            b_prev_q    <= 1'b0;
            hist_q      <= '0;
            quad_q      <= QUAD_ZERO;
            rom_index_q <= '0;
            curve_sel_q <= '0;
            negate_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            b_prev_q    <= b_prev_d;
            hist_q      <= hist_d;
            quad_q      <= quad_d;
            rom_index_q <= rom_index_d;
            curve_sel_q <= curve_sel_d;
            negate_q    <= negate_d;
            busy_q      <= busy_d;
        end
    end

    assign rom_index = rom_index_q;
    assign curve_sel = curve_sel_q;
    assign negate    = negate_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
